// File: rtl/auth_driver_port_pkg.sv
// Shared types and constants for the PD/DEBUG driver authentication port.
// Holds the FSM encoding, slot/source codes and the lowest-slot scan helper.
package auth_driver_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_SEND      = 3'd4,
        ST_ERASE     = 3'd5
    } state_t;

    localparam logic [1:0] REQ_NONE        = 2'b00;
    localparam logic       SRC_PD          = 1'b0;
    localparam logic       SRC_DEBUG       = 1'b1;
    localparam int         ACK_TIMEOUT_DEF = 1024;
    localparam int         MSG_LEN_DEF     = 32;

    // Returns {hit, slot} for the lowest-index non-empty 2-bit slot of a bitmap.
    function automatic logic [2:0] first_slot(input logic [7:0] bm);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (bm[2*i +: 2] != REQ_NONE) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/auth_driver_port_picker.sv
// Combinational request picker: lowest pending slot per source, round-robin
// between PD and DEBUG when both have work.
module auth_req_picker
    import auth_driver_port_pkg::*;
(
    input  logic [7:0] pend_pd_i,
    input  logic [7:0] pend_dbg_i,
    input  logic       rr_last_i,
    output logic       hit_o,
    output logic       src_o,
    output logic [1:0] slot_o,
    output logic [1:0] code_o
);

    logic [2:0] pd_sel;
    logic [2:0] dbg_sel;
    logic       src_c;
    logic [1:0] slot_c;
    logic [7:0] bm_c;

    assign pd_sel  = first_slot(pend_pd_i);
    assign dbg_sel = first_slot(pend_dbg_i);

    always_comb begin
        src_c  = SRC_PD;
        slot_c = pd_sel[1:0];
        bm_c   = pend_pd_i;
        // Both pending: serve whichever source did not go last.
        if (pd_sel[2] && dbg_sel[2]) begin
            src_c = ~rr_last_i;
        end else if (dbg_sel[2]) begin
            src_c = SRC_DEBUG;
        end
        if (src_c == SRC_DEBUG) begin
            slot_c = dbg_sel[1:0];
            bm_c   = pend_dbg_i;
        end
    end

    assign hit_o  = pd_sel[2] | dbg_sel[2];
    assign src_o  = src_c;
    assign slot_o = slot_c;
    assign code_o = 2'(bm_c >> {slot_c, 1'b0});

endmodule

// File: rtl/auth_driver_port.sv
// Controller-side endpoint of the PD/DEBUG authentication interface: accepts a
// pending slot, fetches its message, runs it through the engine, returns the reply, erases the slot.
module auth_driver_port
    import auth_driver_port_pkg::*;
#(
    parameter int MSG_LEN     = MSG_LEN_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               resp_req_in,
    output logic               resp_req_out,
    input  logic [7:0]         pending_auth_request_PD,
    input  logic [7:0]         pending_auth_request_DEBUG,
    output logic               PD_ready,
    output logic               DEBUG_ready,
    input  logic               PD_msg_ready,
    input  logic               DEBUG_msg_ready,
    input  logic [MSG_LEN-1:0] auth_msg_in,
    output logic [MSG_LEN-1:0] auth_msg_out,
    output logic               auth_msg_ready,
    input  logic               Ack_in_driver,
    output logic               pending_auth_request_PD_erase,
    output logic               pending_auth_request_DEBUG_erase,
    output logic [1:0]         erase_slot,
    output logic               eng_req_valid,
    input  logic               eng_req_ready,
    output logic               eng_req_src,
    output logic [1:0]         eng_req_code,
    output logic [1:0]         eng_req_slot,
    output logic [MSG_LEN-1:0] eng_req_msg,
    input  logic               eng_resp_valid,
    input  logic [MSG_LEN-1:0] eng_resp_msg,
    output logic               err_timeout
);

    localparam logic [15:0] TMR_LAST = 16'(ACK_TIMEOUT - 1);

    state_t             state_q;
    logic [15:0]        timer_q;
    logic               rr_last_q;
    logic               src_q;
    logic [1:0]         slot_q;
    logic [1:0]         code_q;
    logic [MSG_LEN-1:0] req_msg_q;
    logic [MSG_LEN-1:0] resp_msg_q;
    logic               resp_req_out_q;
    logic               pd_ready_q;
    logic               dbg_ready_q;
    logic               eng_req_valid_q;
    logic               auth_msg_ready_q;
    logic               pd_erase_q;
    logic               dbg_erase_q;
    logic [1:0]         erase_slot_q;
    logic               err_timeout_q;

    logic               pick_hit;
    logic               pick_src;
    logic [1:0]         pick_slot;
    logic [1:0]         pick_code;
    logic               adv_d;
    logic               timed_d;

    auth_req_picker u_picker (
        .pend_pd_i  (pending_auth_request_PD),
        .pend_dbg_i (pending_auth_request_DEBUG),
        .rr_last_i  (rr_last_q),
        .hit_o      (pick_hit),
        .src_o      (pick_src),
        .slot_o     (pick_slot),
        .code_o     (pick_code)
    );

    // Handshake that moves the current waiting state forward.
    always_comb begin
        adv_d   = 1'b0;
        timed_d = 1'b1;
        case (state_q)
            ST_FETCH:     adv_d = (src_q == SRC_DEBUG) ? DEBUG_msg_ready : PD_msg_ready;
            ST_ISSUE:     adv_d = eng_req_ready;
            ST_WAIT_RESP: adv_d = eng_resp_valid;
            ST_SEND:      adv_d = Ack_in_driver;
            default:      timed_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            timer_q          <= '0;
            rr_last_q        <= SRC_DEBUG;
            src_q            <= SRC_PD;
            slot_q           <= '0;
            code_q           <= '0;
            req_msg_q        <= '0;
            resp_msg_q       <= '0;
            resp_req_out_q   <= 1'b0;
            pd_ready_q       <= 1'b0;
            dbg_ready_q      <= 1'b0;
            eng_req_valid_q  <= 1'b0;
            auth_msg_ready_q <= 1'b0;
            pd_erase_q       <= 1'b0;
            dbg_erase_q      <= 1'b0;
            erase_slot_q     <= '0;
            err_timeout_q    <= 1'b0;
        end else begin
            resp_req_out_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            pd_erase_q     <= 1'b0;
            dbg_erase_q    <= 1'b0;
            erase_slot_q   <= '0;
            timer_q        <= '0;
            if (timed_d && !adv_d && timer_q == TMR_LAST) begin
                // Abort: no erase, but still rotate so the other source gets a turn.
                pd_ready_q       <= 1'b0;
                dbg_ready_q      <= 1'b0;
                eng_req_valid_q  <= 1'b0;
                auth_msg_ready_q <= 1'b0;
                err_timeout_q    <= 1'b1;
                rr_last_q        <= src_q;
                state_q          <= ST_IDLE;
            end else if (timed_d && !adv_d) begin
                timer_q <= timer_q + 16'd1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (resp_req_in && pick_hit) begin
                            resp_req_out_q <= 1'b1;
                            src_q          <= pick_src;
                            slot_q         <= pick_slot;
                            code_q         <= pick_code;
                            pd_ready_q     <= (pick_src == SRC_PD);
                            dbg_ready_q    <= (pick_src == SRC_DEBUG);
                            state_q        <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        req_msg_q       <= auth_msg_in;
                        pd_ready_q      <= 1'b0;
                        dbg_ready_q     <= 1'b0;
                        eng_req_valid_q <= 1'b1;
                        state_q         <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        eng_req_valid_q <= 1'b0;
                        state_q         <= ST_WAIT_RESP;
                    end
                    ST_WAIT_RESP: begin
                        resp_msg_q       <= eng_resp_msg;
                        auth_msg_ready_q <= 1'b1;
                        state_q          <= ST_SEND;
                    end
                    ST_SEND: begin
                        auth_msg_ready_q <= 1'b0;
                        pd_erase_q       <= (src_q == SRC_PD);
                        dbg_erase_q      <= (src_q == SRC_DEBUG);
                        erase_slot_q     <= slot_q;
                        state_q          <= ST_ERASE;
                    end
                    ST_ERASE: begin
                        rr_last_q <= src_q;
                        state_q   <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign resp_req_out                     = resp_req_out_q;
    assign PD_ready                         = pd_ready_q;
    assign DEBUG_ready                      = dbg_ready_q;
    assign auth_msg_out                     = resp_msg_q;
    assign auth_msg_ready                   = auth_msg_ready_q;
    assign pending_auth_request_PD_erase    = pd_erase_q;
    assign pending_auth_request_DEBUG_erase = dbg_erase_q;
    assign erase_slot                       = erase_slot_q;
    assign eng_req_valid                    = eng_req_valid_q;
    assign eng_req_src                      = src_q;
    assign eng_req_code                     = code_q;
    assign eng_req_slot                     = slot_q;
    assign eng_req_msg                      = req_msg_q;
    assign err_timeout                      = err_timeout_q;

endmodule

// File: tb/tb_auth_driver_port.sv
// Directed bench for auth_driver_port: full transactions, round-robin,
// timeout abort, async reset mid-transaction and acceptance gating.
module tb_auth_driver_port;

    localparam int MSG_LEN = 32;
    localparam int ACK_TO  = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic               resp_req_in;
    logic               resp_req_out;
    logic [7:0]         pd_bm;
    logic [7:0]         dbg_bm;
    logic               PD_ready;
    logic               DEBUG_ready;
    logic               PD_msg_ready;
    logic               DEBUG_msg_ready;
    logic [MSG_LEN-1:0] auth_msg_in;
    logic [MSG_LEN-1:0] auth_msg_out;
    logic               auth_msg_ready;
    logic               Ack_in_driver;
    logic               pd_erase;
    logic               dbg_erase;
    logic [1:0]         erase_slot;
    logic               eng_req_valid;
    logic               eng_req_ready;
    logic               eng_req_src;
    logic [1:0]         eng_req_code;
    logic [1:0]         eng_req_slot;
    logic [MSG_LEN-1:0] eng_req_msg;
    logic               eng_resp_valid;
    logic [MSG_LEN-1:0] eng_resp_msg;
    logic               err_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    auth_driver_port #(.MSG_LEN(MSG_LEN), .ACK_TIMEOUT(ACK_TO)) dut (
        .clk                              (clk),
        .reset                            (reset),
        .resp_req_in                      (resp_req_in),
        .resp_req_out                     (resp_req_out),
        .pending_auth_request_PD          (pd_bm),
        .pending_auth_request_DEBUG       (dbg_bm),
        .PD_ready                         (PD_ready),
        .DEBUG_ready                      (DEBUG_ready),
        .PD_msg_ready                     (PD_msg_ready),
        .DEBUG_msg_ready                  (DEBUG_msg_ready),
        .auth_msg_in                      (auth_msg_in),
        .auth_msg_out                     (auth_msg_out),
        .auth_msg_ready                   (auth_msg_ready),
        .Ack_in_driver                    (Ack_in_driver),
        .pending_auth_request_PD_erase    (pd_erase),
        .pending_auth_request_DEBUG_erase (dbg_erase),
        .erase_slot                       (erase_slot),
        .eng_req_valid                    (eng_req_valid),
        .eng_req_ready                    (eng_req_ready),
        .eng_req_src                      (eng_req_src),
        .eng_req_code                     (eng_req_code),
        .eng_req_slot                     (eng_req_slot),
        .eng_req_msg                      (eng_req_msg),
        .eng_resp_valid                   (eng_resp_valid),
        .eng_resp_msg                     (eng_resp_msg),
        .err_timeout                      (err_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Full transaction from IDLE; rearm raises resp_req_in during ERASE to probe spacing.
    task automatic txn(input logic s, input logic [1:0] sl, input logic [1:0] cd,
                       input logic [31:0] m, input logic [31:0] r,
                       input bit clr, input bit rearm, input string t);
        resp_req_in = 1'b1;
        step();
        chk({t, ".accept"}, 64'(resp_req_out), 64'd1);
        chk({t, ".ready"}, 64'({PD_ready, DEBUG_ready}), s ? 64'd1 : 64'd2);
        resp_req_in = 1'b0;
        if (clr) begin
            pd_bm  = 8'h00;
            dbg_bm = 8'h00;
        end
        if (s) PD_msg_ready = 1'b1; else DEBUG_msg_ready = 1'b1;
        auth_msg_in = ~m;
        step();
        chk({t, ".other_src_ignored"}, 64'({PD_ready, DEBUG_ready, eng_req_valid}), s ? 64'd2 : 64'd4);
        PD_msg_ready = 1'b0;
        DEBUG_msg_ready = 1'b0;
        if (s) DEBUG_msg_ready = 1'b1; else PD_msg_ready = 1'b1;
        auth_msg_in = m;
        step();
        PD_msg_ready = 1'b0;
        DEBUG_msg_ready = 1'b0;
        auth_msg_in = '0;
        chk({t, ".issue_flags"}, 64'({PD_ready, DEBUG_ready, eng_req_valid}), 64'd1);
        chk({t, ".issue_hdr"}, 64'({eng_req_src, eng_req_code, eng_req_slot}), 64'({s, cd, sl}));
        chk({t, ".issue_msg"}, 64'(eng_req_msg), 64'(m));
        Ack_in_driver = 1'b1;
        step();
        Ack_in_driver = 1'b0;
        chk({t, ".issue_hold"}, 64'({eng_req_valid, auth_msg_ready}), 64'd2);
        eng_req_ready = 1'b1;
        step();
        eng_req_ready = 1'b0;
        chk({t, ".issue_done"}, 64'(eng_req_valid), 64'd0);
        eng_resp_valid = 1'b1;
        eng_resp_msg   = r;
        step();
        eng_resp_valid = 1'b0;
        eng_resp_msg   = '0;
        chk({t, ".send_ready"}, 64'(auth_msg_ready), 64'd1);
        chk({t, ".send_msg"}, 64'(auth_msg_out), 64'(r));
        step();
        step();
        chk({t, ".send_hold"}, 64'({auth_msg_ready, auth_msg_out}), 64'({1'b1, r}));
        Ack_in_driver = 1'b1;
        step();
        Ack_in_driver = 1'b0;
        chk({t, ".erase"}, 64'({auth_msg_ready, pd_erase, dbg_erase, erase_slot}),
            64'({1'b0, ~s, s, sl}));
        resp_req_in = rearm;
        step();
        chk({t, ".erase_end"}, 64'({pd_erase, dbg_erase, resp_req_out}), 64'd0);
    endtask

    initial begin
        bit seen;
        reset           = 1'b0;
        resp_req_in     = 1'b0;
        pd_bm           = 8'h00;
        dbg_bm          = 8'h00;
        PD_msg_ready    = 1'b0;
        DEBUG_msg_ready = 1'b0;
        auth_msg_in     = '0;
        Ack_in_driver   = 1'b0;
        eng_req_ready   = 1'b0;
        eng_resp_valid  = 1'b0;
        eng_resp_msg    = '0;
        #1;
        chk("reset.ctrl", 64'({resp_req_out, PD_ready, DEBUG_ready, auth_msg_ready, pd_erase,
            dbg_erase, erase_slot, eng_req_valid, eng_req_src, eng_req_code, eng_req_slot,
            err_timeout}), 64'd0);
        chk("reset.data", 64'({auth_msg_out, eng_req_msg}), 64'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // DEBUG only, lowest slot 0 carries code 2'b10.
        dbg_bm = 8'b00_10_01_10;
        txn(1'b1, 2'd0, 2'b10, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0, "t1");

        // Both pending: PD first after DEBUG was served, then DEBUG; no same-cycle re-arm.
        pd_bm  = 8'h03;
        dbg_bm = 8'h03;
        txn(1'b0, 2'd0, 2'b11, 32'h5555_0001, 32'h6666_0001, 1'b0, 1'b1, "t2a");
        txn(1'b1, 2'd0, 2'b11, 32'h5555_0002, 32'h6666_0002, 1'b0, 1'b0, "t2b");

        // PD slot 3; bitmaps cleared mid-transaction must not disturb it.
        pd_bm  = 8'b11_00_00_00;
        dbg_bm = 8'h00;
        txn(1'b0, 2'd3, 2'b11, 32'hCAFE_0003, 32'hA5A5_5A5A, 1'b1, 1'b0, "t3");

        // Ack withheld: abort after ACK_TO cycles in SEND, no erase.
        dbg_bm = 8'h04;
        resp_req_in = 1'b1;
        step();
        chk("t4.accept", 64'({resp_req_out, DEBUG_ready}), 64'd3);
        resp_req_in = 1'b0;
        DEBUG_msg_ready = 1'b1;
        step();
        DEBUG_msg_ready = 1'b0;
        eng_req_ready = 1'b1;
        step();
        eng_req_ready = 1'b0;
        eng_resp_valid = 1'b1;
        eng_resp_msg = 32'hDEAD_BEEF;
        step();
        eng_resp_valid = 1'b0;
        eng_resp_msg = '0;
        chk("t4.send", 64'({auth_msg_ready, eng_req_slot, eng_req_code}), 64'({1'b1, 2'd1, 2'b01}));
        repeat (ACK_TO - 1) step();
        chk("t4.before_to", 64'({auth_msg_ready, err_timeout}), 64'd2);
        step();
        chk("t4.timeout", 64'({err_timeout, auth_msg_ready, pd_erase, dbg_erase}), 64'd8);
        step();
        chk("t4.err_pulse", 64'(err_timeout), 64'd0);

        // Both pending after DEBUG abort -> PD; reset in WAIT_RESP.
        pd_bm  = 8'h01;
        dbg_bm = 8'h01;
        resp_req_in = 1'b1;
        step();
        chk("t5.rr_after_abort", 64'({resp_req_out, PD_ready, DEBUG_ready}), 64'd6);
        resp_req_in = 1'b0;
        PD_msg_ready = 1'b1;
        auth_msg_in = 32'h0BAD_F00D;
        step();
        PD_msg_ready = 1'b0;
        eng_req_ready = 1'b1;
        step();
        eng_req_ready = 1'b0;
        chk("t5.wait_resp", 64'({eng_req_valid, eng_req_code}), 64'd1);
        reset = 1'b0;
        #1;
        chk("t5.reset_ctrl", 64'({resp_req_out, PD_ready, DEBUG_ready, auth_msg_ready, pd_erase,
            dbg_erase, erase_slot, eng_req_valid, eng_req_src, eng_req_code, eng_req_slot,
            err_timeout}), 64'd0);
        chk("t5.reset_data", 64'({auth_msg_out, eng_req_msg}), 64'd0);
        step();
        reset = 1'b1;
        txn(1'b0, 2'd0, 2'b01, 32'h7777_0005, 32'h8888_0005, 1'b0, 1'b0, "t5r");

        // resp_req_in low: nothing accepted.
        pd_bm  = 8'h03;
        dbg_bm = 8'h03;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (resp_req_out || PD_ready || DEBUG_ready) seen = 1'b1;
        end
        chk("t6.no_accept", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
